disp_arbiter: RTL and testbench

- Time-slicing arbiter sharing the four-digit seven-segment display between two requesters A and B.
- Each requester presents a 32-bit segment pattern, one byte per digit, with a request line.
- The arbiter grants one owner at a time for a guaranteed minimum hold period and alternates round-robin when both contend.
- Registered outputs drive the digit inputs of disp_mux directly; idle display is blank.

---
 rtl/disp_arbiter_if.sv | 28 ++
 rtl/disp_arbiter.sv | 171 +++++++++++++++++
 tb/tb_disp_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_arbiter_if.sv
// Display-sharing bus between two requesters and the disp_arbiter.
// Carries both request/data pairs, the grants, the owner code and the
// four registered digit patterns that feed disp_mux.
interface disp_arbiter_if;
    logic        req_a;
    logic [31:0] data_a;
    logic        gnt_a;
    logic        req_b;
    logic [31:0] data_b;
    logic        gnt_b;
    logic [7:0]  in3;
    logic [7:0]  in2;
    logic [7:0]  in1;
    logic [7:0]  in0;
    logic [1:0]  owner;

    // Requester side: drives requests and patterns, observes the display.
    modport master (
        output req_a, data_a, req_b, data_b,
        input  gnt_a, gnt_b, in3, in2, in1, in0, owner
    );

    // Arbiter side.
    modport slave (
        input  req_a, data_a, req_b, data_b,
        output gnt_a, gnt_b, in3, in2, in1, in0, owner
    );
endinterface

// File: rtl/disp_arbiter.sv
// disp_arbiter: time-slicing owner of the four-digit seven-segment display.
// Two requesters share the display; each grant lasts at least
// HOLD_TICKS * TICK_DIV cycles and contention alternates round-robin.
// Optional macro DISP_BLANK_GAP_EN inserts a one-tick blank GAP state on
// every A<->B owner change; without it switches are direct.
module disp_arbiter #(
    parameter int          TICK_DIV   = 100000,
    parameter int          HOLD_TICKS = 1000,
    parameter logic [7:0]  BLANK      = 8'hff
) (
    input  logic           clk,
    input  logic           reset_n,
    disp_arbiter_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_SAT   = HW'(HOLD_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_A = 2'd1,
`ifdef DISP_BLANK_GAP_EN
        S_OWN_B = 2'd2,
        S_GAP   = 2'd3
`else
        S_OWN_B = 2'd2
`endif
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    state_t        w_pick;
    logic [PW-1:0] r_presc;
    logic [HW-1:0] r_hold;
    logic          r_rr;          // 0: A wins a tie, 1: B wins a tie
    logic          w_tick;
    logic          w_expire;
    logic          w_grant_edge;  // new grant or re-grant this edge
    logic          w_gap_entry;   // entering the blank gap (gap build only)

    assign w_tick   = (r_presc == PRESC_LAST);
    assign w_expire = (r_hold == HOLD_LAST) && w_tick;

    // Choice made from an idle display: sole requester, or rr pointer on a tie.
    assign w_pick = (bus.req_a && bus.req_b) ? (r_rr ? S_OWN_B : S_OWN_A) :
                    bus.req_a                ? S_OWN_A :
                    bus.req_b                ? S_OWN_B : S_IDLE;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state decision; an owner is only reconsidered when its hold expires.
    always_comb begin
        w_state_next = r_state;
        w_grant_edge = 1'b0;
        w_gap_entry  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = w_pick;
                w_grant_edge = (w_pick != S_IDLE);
            end
            S_OWN_A: begin
                if (w_expire) begin
                    if (bus.req_b) begin
`ifdef DISP_BLANK_GAP_EN
                        w_state_next = S_GAP;
                        w_gap_entry  = 1'b1;
`else
                        w_state_next = S_OWN_B;
                        w_grant_edge = 1'b1;
`endif
                    end else if (bus.req_a) begin
                        w_state_next = S_OWN_A;
                        w_grant_edge = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_OWN_B: begin
                if (w_expire) begin
                    if (bus.req_a) begin
`ifdef DISP_BLANK_GAP_EN
                        w_state_next = S_GAP;
                        w_gap_entry  = 1'b1;
`else
                        w_state_next = S_OWN_A;
                        w_grant_edge = 1'b1;
`endif
                    end else if (bus.req_b) begin
                        w_state_next = S_OWN_B;
                        w_grant_edge = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
`ifdef DISP_BLANK_GAP_EN
            S_GAP: begin
                // rr already names the pending requester; if it dropped, the
                // pick falls back to plain idle evaluation.
                if (w_tick) begin
                    w_state_next = w_pick;
                    w_grant_edge = (w_pick != S_IDLE);
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Grant and owner outputs decoded from the registered state.
    always_comb begin
        bus.gnt_a = (r_state == S_OWN_A);
        bus.gnt_b = (r_state == S_OWN_B);
        bus.owner = {(r_state == S_OWN_B), (r_state == S_OWN_A)};
    end

    // Tick prescaler, restarted on every grant so a hold is exact in cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        r_presc <= '0;
        else if (w_grant_edge || w_gap_entry) r_presc <= '0;
        else if (w_tick)                     r_presc <= '0;
        else                                 r_presc <= r_presc + PW'(1);
    end

    // Hold counter in ticks; saturates so a long idle never wraps it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        r_hold <= '0;
        else if (w_grant_edge || w_gap_entry) r_hold <= '0;
        else if (w_tick && (r_hold != HOLD_SAT)) r_hold <= r_hold + HW'(1);
    end

    // Round-robin pointer: after each grant, the other requester wins ties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          r_rr <= 1'b0;
        else if (w_grant_edge) r_rr <= (w_state_next == S_OWN_A);
    end

    // Per-digit registers: follow the owner's live data, freeze when it drops
    // its request, blank whenever nobody owns the display.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [7:0] r_digit;
            // Load owner's byte for this digit, hold, or blank.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_digit <= BLANK;
                end else begin
                    case (w_state_next)
                        S_OWN_A: if (bus.req_a) r_digit <= bus.data_a[gi*8 +: 8];
                        S_OWN_B: if (bus.req_b) r_digit <= bus.data_b[gi*8 +: 8];
                        default: r_digit <= BLANK;
                    endcase
                end
            end
        end
    endgenerate

    assign bus.in0 = g_digit[0].r_digit;
    assign bus.in1 = g_digit[1].r_digit;
    assign bus.in2 = g_digit[2].r_digit;
    assign bus.in3 = g_digit[3].r_digit;

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter (TICK_DIV=4, HOLD_TICKS=3).
// The driver sets inputs on the falling edge, steps a cycle-count reference
// model and queues the outputs expected after the next rising edge; the
// monitor pops and compares one entry per rising edge.
module tb_disp_arbiter;
    localparam int          TICK_DIV   = 4;
    localparam int          HOLD_TICKS = 3;
    localparam int          HOLD_CYC   = TICK_DIV * HOLD_TICKS;
    localparam logic [7:0]  BLANK      = 8'hff;
    localparam logic [31:0] BLANK4     = {4{BLANK}};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    disp_arbiter_if bus();

    disp_arbiter #(
        .TICK_DIV  (TICK_DIV),
        .HOLD_TICKS(HOLD_TICKS),
        .BLANK     (BLANK)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic        gnt_a;
        logic        gnt_b;
        logic [1:0]  owner;
        logic [31:0] digits;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;

    // Reference model: owner 0 none, 1 A, 2 B, 3 blank gap; age counts
    // cycles since the current grant (or gap) began.
    int          m_owner;
    int          m_age;
    int          m_rr;
    logic [31:0] m_digits;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_age    = 0;
        m_rr     = 1;
        m_digits = BLANK4;
    endtask

    function automatic int pick(input logic ra, input logic rb);
        if (ra && rb) return m_rr;
        if (ra) return 1;
        if (rb) return 2;
        return 0;
    endfunction

    task automatic model_step(input logic ra, input logic rb,
                              input logic [31:0] da, input logic [31:0] db);
        int nxt;
        bit grant;
        bit restart;
        logic own_req;
        logic other_req;
        nxt = m_owner;
        grant = 1'b0;
        restart = 1'b0;
        if (m_owner == 0) begin
            nxt = pick(ra, rb);
            grant = (nxt != 0);
        end else if (m_owner == 3) begin
            if (m_age == TICK_DIV - 1) begin
                nxt = pick(ra, rb);
                grant = (nxt != 0);
            end
        end else if (m_age == HOLD_CYC - 1) begin
            own_req   = (m_owner == 1) ? ra : rb;
            other_req = (m_owner == 1) ? rb : ra;
            if (other_req) begin
`ifdef DISP_BLANK_GAP_EN
                nxt = 3;
                restart = 1'b1;
`else
                nxt = 3 - m_owner;
                grant = 1'b1;
`endif
            end else if (own_req) begin
                grant = 1'b1;
            end else begin
                nxt = 0;
            end
        end
        if (grant) begin
            m_age = 0;
            m_rr  = 3 - nxt;
        end else if (restart) begin
            m_age = 0;
        end else begin
            m_age++;
        end
        if (nxt == 1) begin
            if (ra) m_digits = da;
        end else if (nxt == 2) begin
            if (rb) m_digits = db;
        end else begin
            m_digits = BLANK4;
        end
        m_owner = nxt;
    endtask

    // mode: 0 both, 1 only A, 2 only B, 3 random persistent, 4 none
    task automatic drive_cycles(input int n, input int mode, input bit rand_data);
        logic ra;
        logic rb;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (mode)
                0: begin ra = 1'b1; rb = 1'b1; end
                1: begin ra = 1'b1; rb = 1'b0; end
                2: begin ra = 1'b0; rb = 1'b1; end
                3: begin
                    ra = ($urandom_range(0, 5) == 0) ? ~bus.req_a : bus.req_a;
                    rb = ($urandom_range(0, 5) == 0) ? ~bus.req_b : bus.req_b;
                end
                default: begin ra = 1'b0; rb = 1'b0; end
            endcase
            if (rand_data && ($urandom_range(0, 2) == 0)) bus.data_a = $urandom;
            if (rand_data && ($urandom_range(0, 2) == 0)) bus.data_b = $urandom;
            bus.req_a = ra;
            bus.req_b = rb;
            model_step(ra, rb, bus.data_a, bus.data_b);
            e.gnt_a  = (m_owner == 1);
            e.gnt_b  = (m_owner == 2);
            e.owner  = {e.gnt_b, e.gnt_a};
            e.digits = m_digits;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one queued expectation per rising edge, sampled 1 ns after it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                check("gnt_a", 64'(bus.gnt_a), 64'(e.gnt_a));
                check("gnt_b", 64'(bus.gnt_b), 64'(e.gnt_b));
                check("owner", 64'(bus.owner), 64'(e.owner));
                check("digits", 64'({bus.in3, bus.in2, bus.in1, bus.in0}), 64'(e.digits));
                $display("txn %0d req=%b%b owner=%b digits=%h", txn,
                         bus.req_b, bus.req_a, bus.owner,
                         {bus.in3, bus.in2, bus.in1, bus.in0});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt_a"}, 64'(bus.gnt_a), 64'(0));
        check({tag, "_gnt_b"}, 64'(bus.gnt_b), 64'(0));
        check({tag, "_owner"}, 64'(bus.owner), 64'(0));
        check({tag, "_digits"}, 64'({bus.in3, bus.in2, bus.in1, bus.in0}), 64'(BLANK4));
    endtask

    initial begin : stimulus
        int wait_cycles;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = 32'h0;
        bus.data_b = 32'h0;
        model_reset();

        // Power-on reset state.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Single requester with the reference pattern, then live data.
        bus.data_a = 32'hC0F9A4B0;
        drive_cycles(1, 1, 1'b0);
        drive_cycles(20, 1, 1'b1);

        // Asynchronous reset while A owns the display.
        drive_cycles(5, 1, 1'b1);
        @(posedge clk);
        #3;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midhold_rst");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Contention from reset: A first, then alternating every hold.
        drive_cycles(40, 0, 1'b1);
        drive_cycles(30, 4, 1'b1);

        // Early drop: A requests for 3 cycles, then freezes until expiry.
        drive_cycles(3, 1, 1'b1);
        drive_cycles(15, 4, 1'b1);

        // Renewal with a lone requester, both sides.
        drive_cycles(30, 1, 1'b1);
        drive_cycles(30, 2, 1'b1);

        // Randomized traffic.
        drive_cycles(400, 3, 1'b1);
        drive_cycles(20, 4, 1'b0);

        // Let the monitor drain the scoreboard, bounded.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
